// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared definitions for the SRAM-backed FIFO controller: pointer width, default thresholds
// and the SRAM_FIFO_ALMOST_FLAGS_EN build switch that enables the almost_full/almost_empty flags.
package sram_fifo_ctrl_pkg;

  localparam int DEFAULT_DATA_WIDTH       = 8;
  localparam int DEFAULT_ADDR_WIDTH       = 8;
  localparam int DEFAULT_ALMOST_EMPTY_LVL = 2;

  // One extra pointer bit acts as the wrap flag that distinguishes full from empty
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int default_almost_full_lvl(input int addr_width);
    return (1 << addr_width) - 2;
  endfunction

`ifdef SRAM_FIFO_ALMOST_FLAGS_EN
  localparam bit ALMOST_FLAGS_EN = 1'b1;
`else
  localparam bit ALMOST_FLAGS_EN = 1'b0;
`endif

endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// Producer/consumer handshake plus the dual-port memory bus driven by sram_fifo_ctrl.
// The slave modport is the controller's view; master is the surrounding environment.
interface sram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  mem_wEn;
  logic [ADDR_WIDTH-1:0] mem_wAddr;
  logic [DATA_WIDTH-1:0] mem_dIn;
  logic [ADDR_WIDTH-1:0] mem_rAddr;
  logic [DATA_WIDTH-1:0] mem_dOut;

  modport slave (
    input  in_data, in_valid, out_ready, mem_dOut,
    output in_ready, out_data, out_valid, mem_wEn, mem_wAddr, mem_dIn, mem_rAddr
  );

  modport master (
    output in_data, in_valid, out_ready, mem_dOut,
    input  in_ready, out_data, out_valid, mem_wEn, mem_wAddr, mem_dIn, mem_rAddr
  );

endinterface

// File: rtl/sram_fifo_ctrl_fifo_ptr_flags.sv
// Read/write pointers, occupancy count and full/empty flags for the SRAM FIFO.
// Optional registered almost flags are built when SRAM_FIFO_ALMOST_FLAGS_EN is defined.
module fifo_ptr_flags
  import sram_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
`ifdef SRAM_FIFO_ALMOST_FLAGS_EN
  ,
  parameter int ALMOST_FULL_LVL  = default_almost_full_lvl(ADDR_WIDTH),
  parameter int ALMOST_EMPTY_LVL = DEFAULT_ALMOST_EMPTY_LVL
`endif
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            clear,
  input  logic                            push,
  input  logic                            pop,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic [ptr_width(ADDR_WIDTH)-1:0] count,
  output logic                            empty,
  output logic                            full
`ifdef SRAM_FIFO_ALMOST_FLAGS_EN
  ,
  output logic                            almost_full,
  output logic                            almost_empty
`endif
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] ONE = PW'(1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count_q;
  logic [PW-1:0] count_next;

  // Occupancy only moves when exactly one side transfers; clear wins over both
  always_comb begin
    count_next = count_q;
    if (clear) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count_q + ONE;
    end else if (pop && !push) begin
      count_next = count_q - ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_next;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + ONE;
        if (pop)  rd_ptr <= rd_ptr + ONE;
      end
    end
  end

  assign wr_addr = wr_ptr[PW-2:0];
  assign rd_addr = rd_ptr[PW-2:0];
  assign count   = count_q;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);

`ifdef SRAM_FIFO_ALMOST_FLAGS_EN
  localparam logic [PW-1:0] AF_LVL = PW'(ALMOST_FULL_LVL);
  localparam logic [PW-1:0] AE_LVL = PW'(ALMOST_EMPTY_LVL);

  // Flags follow count_next so they line up with the registered count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_next >= AF_LVL);
      almost_empty <= (count_next <= AE_LVL);
    end
  end
`endif

endmodule

// File: rtl/sram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around an async-read, sync-write dual-port memory.
// Define SRAM_FIFO_ALMOST_FLAGS_EN to add the almost_full/almost_empty outputs.
module sram_fifo_ctrl
  import sram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
`ifdef SRAM_FIFO_ALMOST_FLAGS_EN
  ,
  parameter int ALMOST_FULL_LVL  = default_almost_full_lvl(ADDR_WIDTH),
  parameter int ALMOST_EMPTY_LVL = DEFAULT_ALMOST_EMPTY_LVL
`endif
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             clear,
  sram_fifo_ctrl_if.slave                  bus,
  output logic [ptr_width(ADDR_WIDTH)-1:0] count
`ifdef SRAM_FIFO_ALMOST_FLAGS_EN
  ,
  output logic                             almost_full,
  output logic                             almost_empty
`endif
);

  logic                  empty;
  logic                  full;
  logic                  in_ready_int;
  logic                  out_valid_int;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_word;

  // Handshakes depend only on registered pointers (and reset), never on valid/ready inputs
  assign in_ready_int  = reset_n & ~full;
  assign out_valid_int = ~empty;
  assign push          = bus.in_valid & in_ready_int;
  assign pop           = out_valid_int & bus.out_ready;

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.mem_wEn   = push;
  assign bus.mem_dIn   = bus.in_data;
  assign head_word     = bus.mem_dOut;
  assign bus.out_data  = head_word;

  fifo_ptr_flags #(
    .ADDR_WIDTH       (ADDR_WIDTH)
`ifdef SRAM_FIFO_ALMOST_FLAGS_EN
    ,
    .ALMOST_FULL_LVL  (ALMOST_FULL_LVL),
    .ALMOST_EMPTY_LVL (ALMOST_EMPTY_LVL)
`endif
  ) u_ptr_flags (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (clear),
    .push         (push),
    .pop          (pop),
    .wr_addr      (bus.mem_wAddr),
    .rd_addr      (bus.mem_rAddr),
    .count        (count),
    .empty        (empty),
    .full         (full)
`ifdef SRAM_FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl (depth 4) against a queue-based reference model,
// with directed scenarios followed by randomized traffic, clears and reset pulses.
module tb_sram_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear   = 1'b0;
  logic [AW:0]   count;
`ifdef SRAM_FIFO_ALMOST_FLAGS_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  sram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  sram_fifo_ctrl #(
    .DATA_WIDTH       (DW),
    .ADDR_WIDTH       (AW)
`ifdef SRAM_FIFO_ALMOST_FLAGS_EN
    ,
    .ALMOST_FULL_LVL  (3),
    .ALMOST_EMPTY_LVL (1)
`endif
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (clear),
    .bus          (bus),
    .count        (count)
`ifdef SRAM_FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  always #5 clock = ~clock;

  // Dual-port memory beside the controller: synchronous write, asynchronous read
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  always @(posedge clock) if (bus.mem_wEn) mem[bus.mem_wAddr] <= bus.mem_dIn;
  assign bus.mem_dOut = mem[bus.mem_rAddr];

  int vectors    = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a queue of words plus running totals of writes and reads
  logic [DW-1:0] q [$];
  int  wr_total = 0;
  int  rd_total = 0;
  bit  m_push;
  bit  m_pop;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      wr_total = 0;
      rd_total = 0;
    end else begin
      m_push = bus.in_valid && (q.size() < DEPTH);
      m_pop  = bus.out_ready && (q.size() > 0);
      if (clear) begin
        q.delete();
        wr_total = 0;
        rd_total = 0;
      end else begin
        if (m_pop) begin
          void'(q.pop_front());
          rd_total++;
        end
        if (m_push) begin
          q.push_back(bus.in_data);
          wr_total++;
        end
      end
    end
  end

  int sz;
  always @(negedge clock) begin
    sz = q.size();
    checkOutput("count",     32'(count),         32'(sz));
    checkOutput("in_ready",  32'(bus.in_ready),  32'(reset_n && sz < DEPTH));
    checkOutput("out_valid", 32'(bus.out_valid), 32'(sz > 0));
    checkOutput("mem_wEn",   32'(bus.mem_wEn),   32'(reset_n && bus.in_valid && sz < DEPTH));
    checkOutput("mem_dIn",   32'(bus.mem_dIn),   32'(bus.in_data));
    checkOutput("mem_wAddr", 32'(bus.mem_wAddr), 32'(wr_total % DEPTH));
    checkOutput("mem_rAddr", 32'(bus.mem_rAddr), 32'(rd_total % DEPTH));
    if (sz > 0) checkOutput("out_data", 32'(bus.out_data), 32'(q[0]));
`ifdef SRAM_FIFO_ALMOST_FLAGS_EN
    checkOutput("almost_empty", 32'(almost_empty), 32'(sz <= 1));
    checkOutput("almost_full",  32'(almost_full),  32'(sz >= 3));
`endif
  end

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    clear         = c;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clock);
    #1;
  endtask

  logic [DW-1:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int phase;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #2;
    checkOutput("rst_count",     32'(count),         32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    stepClock();

    // Fill to full, then offer a fifth word that must be refused
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fill[i], 1'b0, 1'b0);
      stepClock();
    end
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    checkOutput("full_count",    32'(count),        32'd4);
    checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("full_wEn",      32'(bus.mem_wEn),  32'd0);
`ifdef SRAM_FIFO_ALMOST_FLAGS_EN
    checkOutput("full_almost_full",  32'(almost_full),  32'd1);
    checkOutput("full_almost_empty", 32'(almost_empty), 32'd0);
`endif
    stepClock();
    checkOutput("full_hold_count", 32'(count), 32'd4);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("drain_data",  32'(bus.out_data),  32'(fill[i]));
      stepClock();
    end
    checkOutput("drained_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("drained_count", 32'(count),         32'd0);

    // One-cycle write-to-visible latency, no bypass while empty
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("lat_before_valid", 32'(bus.out_valid), 32'd0);
    stepClock();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("lat_after_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("lat_after_data",  32'(bus.out_data),  32'hA5);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    stepClock();
    checkOutput("lat_pop_count", 32'(count), 32'd0);

    // Streaming with a 2-word prefill: occupancy holds while pointers wrap
    applyStimulus(1'b1, 8'h60, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 8'h61, 1'b0, 1'b0);
    stepClock();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'(8'h62 + i), 1'b1, 1'b0);
      checkOutput("stream_data", 32'(bus.out_data), 32'(8'(8'h60 + i)));
      stepClock();
      checkOutput("stream_count", 32'(count), 32'd2);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    stepClock();
    stepClock();
    checkOutput("stream_drain_count", 32'(count), 32'd0);

    // clear beats a simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'(8'h71 + i), 1'b0, 1'b0);
      stepClock();
    end
    checkOutput("pre_clear_count", 32'(count), 32'd3);
    applyStimulus(1'b1, 8'h74, 1'b1, 1'b1);
    checkOutput("clear_wEn", 32'(bus.mem_wEn), 32'd1);
    stepClock();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("clear_count", 32'(count),         32'd0);
    checkOutput("clear_valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset in the middle of operation
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 8'(8'h81 + i), 1'b0, 1'b0);
      stepClock();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("pre_reset_count", 32'(count), 32'd2);
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_count",    32'(count),         32'd0);
    checkOutput("async_rst_valid",    32'(bus.out_valid), 32'd0);
    checkOutput("async_rst_in_ready", 32'(bus.in_ready),  32'd0);
`ifdef SRAM_FIFO_ALMOST_FLAGS_EN
    checkOutput("async_rst_almost_empty", 32'(almost_empty), 32'd1);
    checkOutput("async_rst_almost_full",  32'(almost_full),  32'd0);
`endif
    #1;
    reset_n = 1'b1;
    stepClock();

    // Randomized traffic alternating producer-heavy and consumer-heavy phases
    for (int n = 0; n < 2000; n++) begin
      phase = (n / 100) % 2;
      if (phase == 0)
        applyStimulus($urandom_range(0, 4) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 59) == 0);
      else
        applyStimulus($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 4) != 0,
                      $urandom_range(0, 59) == 0);
      if ($urandom_range(0, 249) == 0) begin
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
      end
      stepClock();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
